// File: rtl/button_conditioner_pkg.sv
// +--------------------------------------------------------------------+
// | button_conditioner_pkg - shared types and constants for key inputs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_e;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_SET        = 1;
  localparam int BTN_RESET      = 2;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

`default_nettype wire

// File: rtl/button_debounce_ch.sv
// +--------------------------------------------------------------------+
// | button_debounce_ch - sync, debounce and pulse one button channel   |
// | Rev 1.0 - optional auto-repeat under BUTTON_AUTOREPEAT_EN          |
// +--------------------------------------------------------------------+
`default_nettype none

module button_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press,
  output logic release_pulse,
  output logic level
);

  // The entry sample in RELEASED/PRESSED is the first stable cycle, so the
  // pending state accepts once the incremented count reaches D-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  btn_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       level_q, level_d;

`ifdef BUTTON_AUTOREPEAT_EN
  // REPEAT_PERIOD must not exceed REPEAT_DELAY: the reload value is the gap.
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    level_d = level_q;
    case (state_q)
      ST_RELEASED: begin
        if (sync2_q) begin
          state_d = ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!sync2_q) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_PEND;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_PEND: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase

`ifdef BUTTON_AUTOREPEAT_EN
    // Any cycle outside a steady PRESSED restarts the full initial delay.
    rpt_d = '0;
    if (state_q == ST_PRESSED && sync2_q) begin
      if (rpt_q == RPT_LAST) begin
        rpt_d   = RPT_RELOAD;
        press_d = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      level_q <= level_d;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign press         = press_q;
  assign release_pulse = rel_q;
  assign level         = level_q;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// +--------------------------------------------------------------------+
// | button_conditioner - N debounced push-button channels, press pulses |
// | Rev 1.0 - optional auto-repeat under BUTTON_AUTOREPEAT_EN           |
// +--------------------------------------------------------------------+
`default_nettype none

module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] key_n,
  output logic [N_BTN-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] level
);

  logic [N_BTN-1:0] btn_pressed;

  assign btn_pressed = (ACTIVE_LOW != 0) ? ~key_n : key_n;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_in        (btn_pressed[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .level         (level[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// +--------------------------------------------------------------------+
// | tb_button_conditioner - directed bench with a debounce-rule model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_button_conditioner;

  localparam int N = 3;
  localparam int D = 4;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RD = 8;
  localparam int RP = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] press, release_pulse, level;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .ACTIVE_LOW      (1)
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .press         (press),
    .release_pulse (release_pulse),
    .level         (level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  logic [N-1:0] pin_hist [0:4095];
  logic         rst_hist [0:4095];
  logic [N-1:0] exp_press = '0, exp_rel = '0, exp_level = '0;
  int run      [N] = '{default: 0};
  int next_rep [N] = '{default: 0};

  int dut_press_cnt  [N] = '{default: 0};
  int dut_press_edge [N] = '{default: 0};
  int dut_rel_cnt    [N] = '{default: 0};
  int dut_rel_edge   [N] = '{default: 0};

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edge_no);
    end
  endtask

  // Model: a channel's level flips once D consecutive synchronised samples
  // disagree with it; samples are the pin two edges earlier, or "released"
  // when either of those edges was in reset.
  initial begin : p_model
    logic s;
    forever begin
      @(negedge clk);
      edge_no++;
      if (edge_no > 4095) begin
        $display("FAIL cycle_budget: got %0d expected below 4096", edge_no);
        $fatal(1);
      end
      pin_hist[edge_no] = ~key_n;
      rst_hist[edge_no] = reset;
      exp_press = '0;
      exp_rel   = '0;
      for (int c = 0; c < N; c++) begin
        if (reset) begin
          exp_level[c] = 1'b0;
          run[c]       = 0;
        end else begin
          s = (edge_no >= 3 && !rst_hist[edge_no-1] && !rst_hist[edge_no-2])
              ? pin_hist[edge_no-2][c] : 1'b0;
          if (s != exp_level[c]) begin
            run[c]++;
            if (run[c] == D) begin
              exp_level[c] = s;
              run[c]       = 0;
              if (s) begin
                exp_press[c] = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                next_rep[c] = edge_no + RD;
`endif
              end else begin
                exp_rel[c] = 1'b1;
              end
            end
          end else begin
`ifdef BUTTON_AUTOREPEAT_EN
            if (exp_level[c] && run[c] > 0) begin
              next_rep[c] = edge_no + RD;
            end else if (exp_level[c] && edge_no == next_rep[c]) begin
              exp_press[c] = 1'b1;
              next_rep[c]  = edge_no + RP;
            end
`endif
            run[c] = 0;
          end
        end
      end
      chk("press_vs_model",   int'(press),         int'(exp_press));
      chk("release_vs_model", int'(release_pulse), int'(exp_rel));
      chk("level_vs_model",   int'(level),         int'(exp_level));
      for (int c = 0; c < N; c++) begin
        if (press[c]) begin
          dut_press_cnt[c]++;
          dut_press_edge[c] = edge_no;
        end
        if (release_pulse[c]) begin
          dut_rel_cnt[c]++;
          dut_rel_edge[c] = edge_no;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : p_stim
    int b;
    reset = 1'b1;
    key_n = '1;
    tick(3);
    chk("reset_press",   int'(press), 0);
    chk("reset_release", int'(release_pulse), 0);
    chk("reset_level",   int'(level), 0);
    reset = 1'b0;
    tick(3);

`ifndef BUTTON_AUTOREPEAT_EN
    // clean press on ch0
    b = edge_no;
    key_n[0] = 1'b0;
    tick(20);
    chk("clean_press_count", dut_press_cnt[0], 1);
    chk("clean_press_edge",  dut_press_edge[0], b + 6);
    chk("clean_level",       int'(level), 1);
    chk("clean_other_ch",    dut_press_cnt[1] + dut_press_cnt[2], 0);

    // release on ch0
    b = edge_no;
    key_n[0] = 1'b1;
    tick(12);
    chk("release_count", dut_rel_cnt[0], 1);
    chk("release_edge",  dut_rel_edge[0], b + 6);
    chk("release_level", int'(level), 0);

    // bounce on ch1
    key_n[1] = 1'b0; tick(1);
    key_n[1] = 1'b1; tick(1);
    key_n[1] = 1'b0; tick(1);
    key_n[1] = 1'b1; tick(1);
    b = edge_no;
    key_n[1] = 1'b0;
    tick(12);
    chk("bounce_press_count", dut_press_cnt[1], 1);
    chk("bounce_press_edge",  dut_press_edge[1], b + 6);
    key_n[1] = 1'b1;
    tick(12);
    chk("bounce_release_count", dut_rel_cnt[1], 1);

    // three-cycle glitch on ch2
    key_n[2] = 1'b0;
    tick(3);
    key_n[2] = 1'b1;
    tick(10);
    chk("glitch_press_count",   dut_press_cnt[2], 0);
    chk("glitch_release_count", dut_rel_cnt[2], 0);
    chk("glitch_level",         int'(level[2]), 0);

    // reset in the middle of a press debounce
    b = edge_no;
    key_n[0] = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("mid_reset_outputs", int'({press, release_pulse, level}), 0);
    reset = 1'b0;
    tick(12);
    chk("mid_reset_press_count", dut_press_cnt[0], 2);
    chk("mid_reset_press_edge",  dut_press_edge[0], b + 9);

    // button held through a reset is pressed again afterwards
    reset = 1'b1;
    tick(2);
    chk("held_reset_level", int'(level), 0);
    b = edge_no;
    reset = 1'b0;
    tick(10);
    chk("held_press_count", dut_press_cnt[0], 3);
    chk("held_press_edge",  dut_press_edge[0], b + 6);
    chk("held_no_release",  dut_rel_cnt[0], 1);

    key_n = '1;
    tick(12);

    // simultaneous press and release on every channel
    b = edge_no;
    key_n = '0;
    tick(12);
    for (int c = 0; c < N; c++) chk("simul_press_edge", dut_press_edge[c], b + 6);
    b = edge_no;
    key_n = '1;
    tick(12);
    for (int c = 0; c < N; c++) chk("simul_release_edge", dut_rel_edge[c], b + 6);
`else
    // hold ch0 for 30 cycles: pulses every RP after an initial RD
    b = edge_no;
    key_n[0] = 1'b0;
    tick(14);
    chk("repeat_second_count", dut_press_cnt[0], 2);
    chk("repeat_second_edge",  dut_press_edge[0], b + 14);
    tick(16);
    key_n[0] = 1'b1;
    tick(12);
    chk("repeat_total_count", dut_press_cnt[0], 8);
    chk("repeat_last_edge",   dut_press_edge[0], b + 32);
    chk("repeat_release_edge", dut_rel_edge[0], b + 36);
    chk("repeat_level",       int'(level), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
